pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_return_stack.sv | 55 +++++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
// Op encodings and the decoded-control bundle.
package pc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    PC_INC    = 3'd0,
    PC_JUMP   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4
  } pc_op_e;

  typedef struct packed {
    logic jump;
    logic branch;
    logic call;
    logic ret;
  } pc_dec_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control and status bundle of the program-counter sequencer.
// master drives the controls, slave presents PC and stack status.
interface pc_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);

  localparam int DW = $clog2(DEPTH + 1);

  logic             en;
  logic [2:0]       op;
  logic             cond;
  logic [WIDTH-1:0] target;
  logic             clr_fault;
  logic [WIDTH-1:0] pc;
  logic [DW-1:0]    depth;
  logic             stack_full;
  logic             stack_empty;
  logic             fault;

  modport master (
    output en, op, cond, target, clr_fault,
    input  pc, depth, stack_full, stack_empty, fault
  );

  modport slave (
    input  en, op, cond, target, clr_fault,
    output pc, depth, stack_full, stack_empty, fault
  );

endinterface

// File: rtl/pc_return_stack.sv
// LIFO of return addresses; entries are not reset, only the depth.
// dout is the most recently pushed entry while depth is non-zero.
module pc_return_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DW-1:0]    depth_q;
  logic [DW-1:0]    depth_d;
  logic [DW-1:0]    top_full;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && (depth_q != DW'(DEPTH));
  assign do_pop   = pop && !push && (depth_q != '0);
  assign top_full = depth_q - DW'(1);
  assign wr_idx   = depth_q[IW-1:0];
  assign rd_idx   = top_full[IW-1:0];

  always_comb begin
    depth_d = depth_q;
    unique case (1'b1)
      do_push: depth_d = depth_q + DW'(1);
      do_pop:  depth_d = depth_q - DW'(1);
      default: depth_d = depth_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) depth_q <= '0;
    else        depth_q <= depth_d;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= din;
  end

  assign dout  = mem_q[rd_idx];
  assign depth = depth_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with INC/JUMP/BRANCH/CALL/RET and a return stack.
// Stack overflow/underflow leaves PC and stack alone and sets sticky fault.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int RESET_VECTOR = 0,
  parameter int STEP         = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [2:0]                 op,
  input  logic                       cond,
  input  logic [WIDTH-1:0]           target,
  input  logic                       clr_fault,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       fault
);

  localparam int DW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             fault_q;
  logic             fault_d;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] br_pc;
  logic [WIDTH-1:0] ret_pc;
  logic [DW-1:0]    depth_w;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             err;
  pc_dec_t          dec;

  assign seq_pc = pc_q + WIDTH'(STEP);
  // Same-width add is the sign-extended offset add modulo 2^WIDTH
  assign br_pc  = pc_q + target;
  assign full   = (depth_w == DW'(DEPTH));
  assign empty  = (depth_w == '0);

  always_comb begin
    dec = '0;
    unique case (1'b1)
      (op == PC_JUMP):   dec.jump   = 1'b1;
      (op == PC_BRANCH): dec.branch = 1'b1;
      (op == PC_CALL):   dec.call   = 1'b1;
      (op == PC_RET):    dec.ret    = 1'b1;
      default:           dec        = '0;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    push = 1'b0;
    pop  = 1'b0;
    err  = 1'b0;
    if (en) begin
      unique case (1'b1)
        dec.jump:   pc_d = target;
        dec.branch: pc_d = cond ? br_pc : seq_pc;
        dec.call: begin
          if (full) begin
            err = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = target;
          end
        end
        dec.ret: begin
          if (empty) begin
            err = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = ret_pc;
          end
        end
        default:    pc_d = seq_pc;
      endcase
    end
  end

  // A new fault on the same edge as clr_fault wins
  assign fault_d = err | (fault_q & ~clr_fault);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= WIDTH'(RESET_VECTOR);
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  pc_return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (seq_pc),
    .dout  (ret_pc),
    .depth (depth_w)
  );

  assign pc          = pc_q;
  assign depth       = depth_w;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign fault       = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a queue-based scoreboard.
// Stimulus pushes expectations; the monitor pops and compares.
module tb_pc_sequencer;
  import pc_pkg::*;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       fault;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t cur;
  event sample_ev;

  pc_sequencer_if #(.WIDTH(8), .DEPTH(4)) sif ();

  pc_sequencer #(
    .WIDTH        (8),
    .DEPTH        (4),
    .RESET_VECTOR (0),
    .STEP         (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (sif.en),
    .op          (sif.op),
    .cond        (sif.cond),
    .target      (sif.target),
    .clr_fault   (sif.clr_fault),
    .pc          (sif.pc),
    .depth       (sif.depth),
    .stack_full  (sif.stack_full),
    .stack_empty (sif.stack_empty),
    .fault       (sif.fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_now(input string nm, input logic [7:0] p,
                            input logic [2:0] d, input logic f);
    exp_t e;
    e.name  = nm;
    e.pc    = p;
    e.depth = d;
    e.full  = (d == 3'd4);
    e.empty = (d == 3'd0);
    e.fault = f;
    sb.push_back(e);
  endtask

  task automatic step(input string nm, input logic e, input logic [2:0] o,
                      input logic c, input logic [7:0] t, input logic clr,
                      input logic [7:0] ep, input logic [2:0] ed,
                      input logic ef);
    sif.en        = e;
    sif.op        = o;
    sif.cond      = c;
    sif.target    = t;
    sif.clr_fault = clr;
    @(posedge clk);
    #1;
    expect_now(nm, ep, ed, ef);
    @(negedge clk);
  endtask

  always @(negedge clk or sample_ev) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      checks++;
      if (sif.pc !== cur.pc || sif.depth !== cur.depth ||
          sif.stack_full !== cur.full || sif.stack_empty !== cur.empty ||
          sif.fault !== cur.fault) begin
        errors++;
        $display("FAIL %s: got pc=%h depth=%0d full=%b empty=%b fault=%b want pc=%h depth=%0d full=%b empty=%b fault=%b",
                 cur.name, sif.pc, sif.depth, sif.stack_full,
                 sif.stack_empty, sif.fault, cur.pc, cur.depth,
                 cur.full, cur.empty, cur.fault);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    sif.en        = 1'b0;
    sif.op        = PC_INC;
    sif.cond      = 1'b0;
    sif.target    = 8'h00;
    sif.clr_fault = 1'b0;
    #1;
    expect_now("reset", 8'h00, 3'd0, 1'b0);
    -> sample_ev;
    #11;
    reset = 1'b1;

    step("inc1", 1, PC_INC, 0, 8'h00, 0, 8'h01, 3'd0, 0);
    step("inc2", 1, PC_INC, 0, 8'h00, 0, 8'h02, 3'd0, 0);
    step("inc3", 1, PC_INC, 0, 8'h00, 0, 8'h03, 3'd0, 0);
    step("jmp_ff", 1, PC_JUMP, 0, 8'hFF, 0, 8'hFF, 3'd0, 0);
    step("inc_wrap", 1, PC_INC, 0, 8'h00, 0, 8'h00, 3'd0, 0);
    step("jmp_10a", 1, PC_JUMP, 0, 8'h10, 0, 8'h10, 3'd0, 0);
    step("br_taken", 1, PC_BRANCH, 1, 8'hFC, 0, 8'h0C, 3'd0, 0);
    step("jmp_10b", 1, PC_JUMP, 0, 8'h10, 0, 8'h10, 3'd0, 0);
    step("br_not", 1, PC_BRANCH, 0, 8'hFC, 0, 8'h11, 3'd0, 0);
    step("jmp_20", 1, PC_JUMP, 0, 8'h20, 0, 8'h20, 3'd0, 0);
    step("call_80", 1, PC_CALL, 0, 8'h80, 0, 8'h80, 3'd1, 0);
    step("ret_21", 1, PC_RET, 0, 8'h00, 0, 8'h21, 3'd0, 0);
    step("jmp_cond", 1, PC_JUMP, 1, 8'h30, 0, 8'h30, 3'd0, 0);
    step("inc_cond", 1, PC_INC, 1, 8'h99, 0, 8'h31, 3'd0, 0);
    step("op7_inc", 1, 3'd7, 1, 8'h99, 0, 8'h32, 3'd0, 0);

    step("call1", 1, PC_CALL, 0, 8'h40, 0, 8'h40, 3'd1, 0);
    step("call2", 1, PC_CALL, 1, 8'h50, 0, 8'h50, 3'd2, 0);
    step("call3", 1, PC_CALL, 0, 8'h60, 0, 8'h60, 3'd3, 0);
    step("call4", 1, PC_CALL, 0, 8'h70, 0, 8'h70, 3'd4, 0);
    step("call_ovf", 1, PC_CALL, 0, 8'h90, 0, 8'h70, 3'd4, 1);
    step("ret4", 1, PC_RET, 0, 8'h00, 0, 8'h61, 3'd3, 1);
    step("ret3", 1, PC_RET, 1, 8'h00, 0, 8'h51, 3'd2, 1);
    step("ret2", 1, PC_RET, 0, 8'h00, 0, 8'h41, 3'd1, 1);
    step("ret1", 1, PC_RET, 0, 8'h00, 0, 8'h33, 3'd0, 1);
    step("ret_unf", 1, PC_RET, 0, 8'h00, 0, 8'h33, 3'd0, 1);

    step("hold_clr", 0, PC_JUMP, 0, 8'h55, 1, 8'h33, 3'd0, 0);
    step("set_wins", 1, PC_RET, 0, 8'h00, 1, 8'h33, 3'd0, 1);
    step("hold", 0, PC_JUMP, 0, 8'h55, 0, 8'h33, 3'd0, 1);
    step("inc_clr", 1, PC_INC, 0, 8'h00, 1, 8'h34, 3'd0, 0);

    step("callA", 1, PC_CALL, 0, 8'hA0, 0, 8'hA0, 3'd1, 0);
    step("callB", 1, PC_CALL, 0, 8'hB0, 0, 8'hB0, 3'd2, 0);
    sif.en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    expect_now("async_rst", 8'h00, 3'd0, 1'b0);
    -> sample_ev;
    #1;
    reset = 1'b1;
    step("post_rst", 1, PC_INC, 0, 8'h00, 0, 8'h01, 3'd0, 0);
    step("rst_drop", 1, PC_RET, 0, 8'h00, 0, 8'h01, 3'd0, 1);

    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
